// File: rtl/lenet_pkg.sv
// Shared constants for the LeNet frame scheduler: FSM encodings, layer indices, layer count.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lenet_pkg;

    localparam int NUM_LAYERS = 5;
    localparam int IDX_W      = 3;

    // One-hot FSM encodings, kept as plain constants so older tools can read them
    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_START = 5'b00010;
    localparam logic [4:0] ST_WAIT  = 5'b00100;
    localparam logic [4:0] ST_DONE  = 5'b01000;
    localparam logic [4:0] ST_ERR   = 5'b10000;

    // Execution order of the layer controllers
    localparam logic [IDX_W-1:0] L_CONV1 = 3'd0;
    localparam logic [IDX_W-1:0] L_POOL1 = 3'd1;
    localparam logic [IDX_W-1:0] L_CONV2 = 3'd2;
    localparam logic [IDX_W-1:0] L_POOL2 = 3'd3;
    localparam logic [IDX_W-1:0] L_FC    = 3'd4;

endpackage

// File: rtl/lenet_layer_seq_if.sv
// Bundle between the frame scheduler and its environment (host + layer controllers).
// Latency: n/a (wires only).
// Backpressure: none; all signals are single-cycle pulses or levels.
interface lenet_layer_seq_if
    import lenet_pkg::*;
#(
    parameter int NUM_LAYERS = lenet_pkg::NUM_LAYERS,
    parameter int CYC_W      = 20
);

    logic                  frame_start;
    logic                  abort;
    logic [NUM_LAYERS-1:0] layer_start;
    logic [NUM_LAYERS-1:0] layer_done;
    logic                  busy;
    logic [IDX_W-1:0]      cur_layer;
    logic                  frame_done;
    logic [CYC_W-1:0]      frame_cycles;
    logic                  err;
    logic [IDX_W-1:0]      err_layer;

    // Scheduler side
    modport master (
        input  frame_start, abort, layer_done,
        output layer_start, busy, cur_layer, frame_done, frame_cycles, err, err_layer
    );

    // Host / layer-controller side
    modport slave (
        output frame_start, abort, layer_done,
        input  layer_start, busy, cur_layer, frame_done, frame_cycles, err, err_layer
    );

endinterface

// File: rtl/lenet_watchdog.sv
// Per-layer watchdog: counts enabled cycles and flags when the count reaches TIMEOUT-1.
// Latency: expire_o follows the registered count combinationally.
// Backpressure: none; the count parks at TIMEOUT-1 instead of wrapping.
module lenet_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Clear wins over count; hold at the expiry value so it never wraps back to quiet
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/lenet_layer_seq.sv
// Frame scheduler: starts each layer controller in order, waits for its done, guards with a watchdog.
// Latency: next layer_start one cycle after a done is sampled; frame_done one cycle after the last done.
// Backpressure: none; frame_start outside IDLE is dropped, abort overrides everything.
module lenet_layer_seq
    import lenet_pkg::*;
#(
    parameter int NUM_LAYERS = lenet_pkg::NUM_LAYERS,
    parameter int TIMEOUT    = 4096,
    parameter int TO_W       = 13,
    parameter int CYC_W      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    lenet_layer_seq_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    logic [4:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CYC_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [NUM_LAYERS-1:0] idx_oh;
    logic                  done_hit;
    logic                  expire;
    logic                  wd_clr;
    logic                  wd_en;

    logic [NUM_LAYERS-1:0] layer_start_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic [CYC_W-1:0]      frame_cycles_q;
    logic                  err_q;
    logic [IDX_W-1:0]      err_layer_q;

    // Only the active layer's done bit matters; all other bits are masked off
    assign idx_oh   = NUM_LAYERS'(1) << idx_q;
    assign done_hit = |(bus.layer_done & idx_oh);

    // Frame cycle counter sticks at all-ones rather than wrapping
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Watchdog restarts with every layer start and on abort, counts only while waiting
    assign wd_clr   = (state_q == ST_START) || bus.abort;
    assign wd_en    = (state_q == ST_WAIT);

    lenet_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (expire)
    );

    // Next state, layer index and frame counter; abort overrides every transition
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if ((state_q == ST_START) || (state_q == ST_WAIT) || (state_q == ST_DONE)) begin
            cnt_d = cnt_inc;
        end
        if (bus.abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        state_d = ST_START;
                        idx_d   = L_CONV1;
                        cnt_d   = '0;
                    end
                end
                ST_START, ST_WAIT: begin
                    // A done arriving together with expiry still counts as done
                    if (done_hit) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_START;
                            idx_d   = idx_q + 1'b1;
                        end
                    end else if ((state_q == ST_WAIT) && expire) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // FSM, index and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output registers decoded from the next state so each output is valid in the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_start_q <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            layer_start_q <= (state_d == ST_START) ? (NUM_LAYERS'(1) << idx_d) : '0;
            busy_q        <= (state_d == ST_START) || (state_d == ST_WAIT);
            frame_done_q  <= (state_d == ST_DONE);
        end
    end

    // Frame latency capture (DONE cycle included) and sticky watchdog error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cycles_q <= '0;
            err_q          <= 1'b0;
            err_layer_q    <= '0;
        end else begin
            if ((state_q == ST_DONE) && !bus.abort) begin
                frame_cycles_q <= cnt_inc;
            end
            if (bus.abort) begin
                err_q       <= 1'b0;
                err_layer_q <= '0;
            end else if ((state_q == ST_WAIT) && (state_d == ST_ERR)) begin
                err_q       <= 1'b1;
                err_layer_q <= idx_q;
            end
        end
    end

    assign bus.layer_start  = layer_start_q;
    assign bus.busy         = busy_q;
    assign bus.cur_layer    = idx_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.frame_cycles = frame_cycles_q;
    assign bus.err          = err_q;
    assign bus.err_layer    = err_layer_q;

endmodule
